// File: rtl/dcache_assoc.sv
// Set-associative write-through word cache with round-robin replacement and a sweep invalidator.
// Lookup is combinational (0 cycles); refills, stores, invalidates and pointer updates commit on the next edge.
// No queuing: while busy is high every request is dropped, and the requester must hold or re-issue it.
module dcache_assoc #(
    parameter int WAYS   = 2,
    parameter int SETS   = 64,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata,
    output logic                  hit,
    input  logic                  wen,
    input  logic                  wfill,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  inv,
    input  logic                  flush,
    output logic                  busy
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sweep_idx_q, sweep_idx_d;

    // Storage. The per-set pointer is held at zero when the cache is direct-mapped.
    logic [WAYS-1:0]    valid_q [SETS];
    logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
    logic [DATA_W-1:0]  data_q  [WAYS][SETS];
    logic [WAY_W-1:0]   ptr_q   [SETS];

    // Per-cycle decoded actions; only one of them can be active at a time.
    logic               sweep_clr;
    logic               inv_go;
    logic               wr_go;

    logic [IDX_W-1:0]   r_idx;
    logic [TAG_W-1:0]   r_tag;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;

    logic               w_hit;
    logic [WAY_W-1:0]   w_hit_way;
    logic               has_free;
    logic [WAY_W-1:0]   free_way;
    logic               replace;
    logic [WAY_W-1:0]   fill_way;
    logic [DATA_W-1:0]  merged;

    assign r_idx = raddr[IDX_W-1:0];
    assign r_tag = raddr[ADDR_W-1:IDX_W];
    assign w_idx = waddr[IDX_W-1:0];
    assign w_tag = waddr[ADDR_W-1:IDX_W];

    assign busy  = (state_q == ST_SWEEP);

    // State register: reset always restarts the sweep from set 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SWEEP;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // Next state and request arbitration: flush beats inv beats wen; losers are dropped.
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        sweep_clr   = 1'b0;
        inv_go      = 1'b0;
        wr_go       = 1'b0;
        case (state_q)
            ST_SWEEP: begin
                sweep_clr   = 1'b1;
                sweep_idx_d = sweep_idx_q + 1'b1;
                if (sweep_idx_q == IDX_W'(SETS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (flush) begin
                    state_d     = ST_SWEEP;
                    sweep_idx_d = '0;
                end else if (inv) begin
                    inv_go = 1'b1;
                end else if (wen) begin
                    wr_go = 1'b1;
                end
            end
            default: begin
                state_d     = ST_SWEEP;
                sweep_idx_d = '0;
            end
        endcase
    end

    // Read port: at most one way can match, so the last match is the only match.
    always_comb begin
        hit   = 1'b0;
        rdata = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!busy && valid_q[r_idx][w] && (tag_q[w][r_idx] == r_tag)) begin
                hit   = 1'b1;
                rdata = data_q[w][r_idx];
            end
        end
    end

    // Write-port tag compare and lowest-numbered invalid way of the addressed set.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        has_free  = 1'b0;
        free_way  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w_idx][w] && (tag_q[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w_idx][w]) begin
                has_free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    // Refill way choice: hit way, else lowest free way, else the round-robin victim.
    always_comb begin
        replace  = !w_hit && !has_free;
        fill_way = ptr_q[w_idx];
        if (w_hit) begin
            fill_way = w_hit_way;
        end else if (has_free) begin
            fill_way = free_way;
        end
    end

    // Byte-masked store data built on top of the hit way's current word.
    always_comb begin
        merged = data_q[w_hit_way][w_idx];
        for (int b = 0; b < NB; b++) begin
            if (wstrb[b]) begin
                merged[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
    end

    // Array updates: sweep clear, single-line invalidate, refill, or store hit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (sweep_clr) begin
                valid_q[sweep_idx_q] <= '0;
                ptr_q[sweep_idx_q]   <= '0;
            end else if (inv_go) begin
                if (w_hit) begin
                    valid_q[w_idx][w_hit_way] <= 1'b0;
                end
            end else if (wr_go && wfill) begin
                valid_q[w_idx][fill_way] <= 1'b1;
                tag_q[fill_way][w_idx]   <= w_tag;
                data_q[fill_way][w_idx]  <= wdata;
                if (replace && (WAYS > 1)) begin
                    ptr_q[w_idx] <= ptr_q[w_idx] + WAY_W'(1);
                end
            end else if (wr_go && w_hit) begin
                data_q[w_hit_way][w_idx] <= merged;
            end
        end
    end

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: stimulus queues expected lookups, a negedge monitor pops and compares.
// Latency: every expectation is checked in the cycle it is issued (lookup is combinational).
// Backpressure: busy is checked as part of every expectation; sweeps are walked cycle by cycle.
module tb_dcache_assoc;

    localparam int WAYS   = 2;
    localparam int SETS   = 64;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    logic                clk;
    logic                reset;
    logic [ADDR_W-1:0]   raddr;
    logic [DATA_W-1:0]   rdata;
    logic                hit;
    logic                wen;
    logic                wfill;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                inv;
    logic                flush;
    logic                busy;

    dcache_assoc #(
        .WAYS   (WAYS),
        .SETS   (SETS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .raddr (raddr),
        .rdata (rdata),
        .hit   (hit),
        .wen   (wen),
        .wfill (wfill),
        .waddr (waddr),
        .wdata (wdata),
        .wstrb (wstrb),
        .inv   (inv),
        .flush (flush),
        .busy  (busy)
    );

    typedef struct packed {
        logic        busy;
        logic        hit;
        logic [31:0] rdata;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  probe  = 1'b0;
    exp_t  mon_e;
    string mon_n;

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Monitor: on each probed cycle, pop one expectation and compare away from the active edge.
    always @(negedge clk) begin
        if (probe) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL monitor: output presented with no expectation queued");
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                if (busy !== mon_e.busy || hit !== mon_e.hit || rdata !== mon_e.rdata) begin
                    errors++;
                    $display("FAIL %s: got busy=%0b hit=%0b rdata=%08h, expected busy=%0b hit=%0b rdata=%08h",
                             mon_n, busy, hit, rdata, mon_e.busy, mon_e.hit, mon_e.rdata);
                end
            end
        end
    end

    // Advance past the next rising edge and return all request inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        wen   = 1'b0;
        wfill = 1'b0;
        inv   = 1'b0;
        flush = 1'b0;
        waddr = '0;
        wdata = '0;
        wstrb = '0;
    endtask

    // Queue one expected lookup result for the current cycle and let the monitor check it.
    task automatic chk(input string n, input logic [ADDR_W-1:0] a,
                       input logic b, input logic h, input logic [31:0] d);
        exp_t e;
        e.busy  = b;
        e.hit   = h;
        e.rdata = d;
        raddr   = a;
        exp_q.push_back(e);
        name_q.push_back(n);
        probe = 1'b1;
        @(negedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic wr(input logic fill, input logic [ADDR_W-1:0] a,
                      input logic [31:0] d, input logic [3:0] s);
        wen   = 1'b1;
        wfill = fill;
        waddr = a;
        wdata = d;
        wstrb = s;
    endtask

    // Called when the next edge is the first sweep edge: busy for SETS-1 more checks, then idle.
    task automatic wait_sweep(input bit poke);
        for (int i = 0; i < SETS - 1; i++) begin
            tick();
            chk("sweep_busy", '0, 1'b1, 1'b0, 32'h0);
            if (poke && i == 10) begin
                flush = 1'b1;
                inv   = 1'b1;
            end
        end
        tick();
        chk("sweep_done", '0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        raddr = '0;
        wen   = 1'b0;
        wfill = 1'b0;
        waddr = '0;
        wdata = '0;
        wstrb = '0;
        inv   = 1'b0;
        flush = 1'b0;

        // Reset held three cycles, then the power-on sweep.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_busy", '0, 1'b1, 1'b0, 32'h0);
        end
        reset = 1'b0;
        wait_sweep(1'b0);

        // Two-way fill of set 0, then round-robin eviction.
        wr(1'b1, 30'h40, 32'h1111_1111, 4'h0); tick();
        wr(1'b1, 30'h80, 32'h2222_2222, 4'h0); tick();
        chk("fill_40", 30'h40, 1'b0, 1'b1, 32'h1111_1111); tick();
        chk("fill_80", 30'h80, 1'b0, 1'b1, 32'h2222_2222); tick();
        wr(1'b1, 30'hC0, 32'h3333_3333, 4'h0); tick();
        chk("evict_40", 30'h40, 1'b0, 1'b0, 32'h0); tick();
        chk("keep_80", 30'h80, 1'b0, 1'b1, 32'h2222_2222); tick();
        chk("fill_C0", 30'hC0, 1'b0, 1'b1, 32'h3333_3333); tick();
        wr(1'b1, 30'h100, 32'h4444_4444, 4'h0); tick();
        chk("evict_80", 30'h80, 1'b0, 1'b0, 32'h0); tick();
        chk("fill_100", 30'h100, 1'b0, 1'b1, 32'h4444_4444); tick();
        chk("keep_C0", 30'hC0, 1'b0, 1'b1, 32'h3333_3333); tick();
        // Refill hit overwrites in place and leaves the pointer on way 0.
        wr(1'b1, 30'hC0, 32'h5555_5555, 4'h0); tick();
        chk("refill_hit", 30'hC0, 1'b0, 1'b1, 32'h5555_5555); tick();
        wr(1'b1, 30'h140, 32'h6666_6666, 4'h0); tick();
        chk("evict_C0", 30'hC0, 1'b0, 1'b0, 32'h0); tick();
        chk("keep_100", 30'h100, 1'b0, 1'b1, 32'h4444_4444); tick();
        chk("fill_140", 30'h140, 1'b0, 1'b1, 32'h6666_6666); tick();
        // Single-line invalidate: hit removes the line, miss changes nothing.
        inv = 1'b1; waddr = 30'h100; tick();
        chk("inv_100", 30'h100, 1'b0, 1'b0, 32'h0); tick();
        chk("inv_keep_140", 30'h140, 1'b0, 1'b1, 32'h6666_6666); tick();
        inv = 1'b1; waddr = 30'h180; tick();
        chk("inv_miss", 30'h140, 1'b0, 1'b1, 32'h6666_6666); tick();

        // Byte-masked stores.
        wr(1'b1, 30'h05, 32'hAABB_CCDD, 4'h0); tick();
        wr(1'b0, 30'h05, 32'h1122_3344, 4'b0101); tick();
        chk("store_merge", 30'h05, 1'b0, 1'b1, 32'hAA22_CC44); tick();
        wr(1'b0, 30'h45, 32'hDEAD_BEEF, 4'hF); tick();
        chk("store_miss", 30'h45, 1'b0, 1'b0, 32'h0); tick();
        chk("store_miss_keep", 30'h05, 1'b0, 1'b1, 32'hAA22_CC44); tick();
        wr(1'b0, 30'h05, 32'hFFFF_FFFF, 4'h0); tick();
        chk("store_nostrb", 30'h05, 1'b0, 1'b1, 32'hAA22_CC44); tick();

        // inv and refill together: inv wins, refill dropped.
        inv = 1'b1; wr(1'b1, 30'h05, 32'h9999_9999, 4'h0); tick();
        chk("inv_beats_fill", 30'h05, 1'b0, 1'b0, 32'h0); tick();
        chk("miss_06", 30'h06, 1'b0, 1'b0, 32'h0); tick();
        // flush and refill together: flush wins; requests during the sweep are ignored.
        flush = 1'b1; wr(1'b1, 30'h06, 32'h6060_6060, 4'h0); tick();
        chk("flush_busy", 30'h140, 1'b1, 1'b0, 32'h0);
        wait_sweep(1'b1);
        tick();
        chk("flush_drop_06", 30'h06, 1'b0, 1'b0, 32'h0); tick();
        chk("flush_clr_140", 30'h140, 1'b0, 1'b0, 32'h0); tick();

        // Reset at sweep index 30 restarts the sweep; the last set is also cleared.
        wr(1'b1, 30'h3F, 32'h3F3F_3F3F, 4'h0); tick();
        chk("fill_last_set", 30'h3F, 1'b0, 1'b1, 32'h3F3F_3F3F); tick();
        flush = 1'b1; tick();
        chk("flush2_busy", '0, 1'b1, 1'b0, 32'h0);
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk("flush2_sweep", '0, 1'b1, 1'b0, 32'h0);
        end
        reset = 1'b1; tick();
        chk("reset_mid", '0, 1'b1, 1'b0, 32'h0);
        reset = 1'b0;
        wait_sweep(1'b0);
        tick();
        chk("last_set_clr", 30'h3F, 1'b0, 1'b0, 32'h0); tick();

        // No same-cycle bypass; write visible the cycle after its edge.
        wr(1'b1, 30'h07, 32'h0000_0005, 4'h0);
        chk("pre_write", 30'h07, 1'b0, 1'b0, 32'h0);
        tick();
        chk("post_write", 30'h07, 1'b0, 1'b1, 32'h0000_0005);
        tick();

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: %0d expectations unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
